// File: rtl/reg_scoreboard.sv
// Register write scoreboard: counts in-flight writes per register and stalls
// decode on RAW hazards or a full counter.
// Latency: stall/issue_ack are combinational; counts update on the next posedge.
// Backpressure: stall holds decode; an issue is consumed only when issue_ack=1.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   src1/src1_valid   first source of the instruction in decode
//   src2/src2_valid   second source of the instruction in decode
//   issue_valid       decode presents an instruction
//   issue_wb_en       the instruction will write issue_dest
//   issue_dest        destination register of the instruction
//   write_back_en     write-back is writing dest_wb this cycle
//   dest_wb           register being written back
//   stall             decode must hold
//   issue_ack         instruction accepted this cycle
//   pending_mask      bit r set while register r has outstanding writes
//   pending_total     sum of all outstanding writes
//   underflow_err     sticky: write-back seen with nothing pending
module reg_scoreboard #(
   parameter int NUM_REGS    = 16,
   parameter int MAX_PENDING = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          src1,
   input  logic                src1_valid,
   input  logic [3:0]          src2,
   input  logic                src2_valid,
   input  logic                issue_valid,
   input  logic                issue_wb_en,
   input  logic [3:0]          issue_dest,
   input  logic                write_back_en,
   input  logic [3:0]          dest_wb,
   output logic                stall,
   output logic                issue_ack,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic [5:0]          pending_total,
   output logic                underflow_err
);

   localparam logic [1:0] LP_MAX = 2'(MAX_PENDING);

   logic [1:0] r_count [NUM_REGS];
   logic       r_underflow;

   // Counts widened to the full 4-bit register address space; addresses
   // beyond NUM_REGS read as zero so any index is safe.
   logic [1:0] w_cnt16 [16];

   generate
      for (genvar g = 0; g < 16; g++) begin : g_pad
         if (g < NUM_REGS) begin : g_live
            assign w_cnt16[g] = r_count[g];
         end else begin : g_dead
            assign w_cnt16[g] = 2'd0;
         end
      end
   endgenerate

   logic       w_wb_live;
   logic       w_underflow;
   logic [1:0] w_eff_src1;
   logic [1:0] w_eff_src2;
   logic       w_dest_full;
   logic       w_inc;
   logic [NUM_REGS-1:0] w_inc_vec;
   logic [NUM_REGS-1:0] w_dec_vec;

   // A write-back only retires something when the target has a pending write;
   // otherwise it is an underflow and the counts are left alone.
   assign w_wb_live   = write_back_en && (w_cnt16[dest_wb] != 2'd0);
   assign w_underflow = write_back_en && (w_cnt16[dest_wb] == 2'd0);

   // The register file writes on the negedge, so a same-cycle write-back
   // already satisfies one outstanding write for decode's reads.
   assign w_eff_src1 = w_cnt16[src1] - {1'b0, (w_wb_live && (dest_wb == src1))};
   assign w_eff_src2 = w_cnt16[src2] - {1'b0, (w_wb_live && (dest_wb == src2))};

   // A full destination is still issuable when write-back frees a slot on
   // the same register this cycle: the increment and decrement cancel.
   assign w_dest_full = (w_cnt16[issue_dest] == LP_MAX) &&
                        !(write_back_en && (dest_wb == issue_dest));

   always_comb begin
      stall = 1'b0;
      if (issue_valid) begin
         stall = (src1_valid  && (w_eff_src1 != 2'd0)) ||
                 (src2_valid  && (w_eff_src2 != 2'd0)) ||
                 (issue_wb_en && w_dest_full);
      end
   end

   assign issue_ack = issue_valid && !stall;
   assign w_inc     = issue_ack && issue_wb_en;

   always_comb begin
      w_inc_vec = '0;
      w_dec_vec = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_inc_vec[i] = w_inc     && (issue_dest == 4'(i));
         w_dec_vec[i] = w_wb_live && (dest_wb    == 4'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_count[i] <= 2'd0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_inc_vec[i] && !w_dec_vec[i]) begin
               r_count[i] <= r_count[i] + 2'd1;
            end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
               r_count[i] <= r_count[i] - 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_underflow <= 1'b0;
      end else if (w_underflow) begin
         r_underflow <= 1'b1;
      end
   end

   assign underflow_err = r_underflow;

   always_comb begin
      pending_mask  = '0;
      pending_total = 6'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
         pending_mask[i] = (r_count[i] != 2'd0);
         pending_total   = pending_total + 6'(r_count[i]);
      end
   end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of architectural registers tracked.
REQ-002 SHALL have parameter MAX_PENDING, default 3, max outstanding writes per register; counter width 2 bits.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port src1, input, 4, first source register of the instruction in decode.
REQ-006 SHALL have port src1_valid, input, 1, src1 is actually read.
REQ-007 SHALL have port src2, input, 4, second source register.
REQ-008 SHALL have port src2_valid, input, 1, src2 is actually read.
REQ-009 SHALL have port issue_valid, input, 1, decode presents an instruction for issue.
REQ-010 SHALL have port issue_wb_en, input, 1, issuing instruction will write a register.
REQ-011 SHALL have port issue_dest, input, 4, destination register of the issuing instruction.
REQ-012 SHALL have port write_back_en, input, 1, write-back stage is writing the register file this cycle.
REQ-013 SHALL have port dest_wb, input, 4, register being written by write-back.
REQ-014 SHALL have port stall, output, 1, decode must hold; instruction not issued.
REQ-015 SHALL have port issue_ack, output, 1, issue accepted this cycle.
REQ-016 SHALL have port pending_mask, output, NUM_REGS, bit r set when count[r] != 0.
REQ-017 SHALL have port pending_total, output, 6, sum of all counts (max 48).
REQ-018 SHALL have port underflow_err, output, 1, sticky retire-without-pending flag.

Function
REQ-019 SHALL hold one 2-bit count[r] per register = issued-but-not-written-back writes to r.
REQ-020 SHALL compute eff[r] = count[r] - 1 when write_back_en and dest_wb == r and count[r] != 0, else count[r]; models the register file's negedge write being visible to same-cycle decode reads.
REQ-021 SHALL assert stall combinationally when issue_valid and any of: src1_valid and eff[src1] != 0; src2_valid and eff[src2] != 0; issue_wb_en and count[issue_dest] == MAX_PENDING (unless same-cycle write-back to issue_dest).
REQ-022 SHALL drive stall = 0 when issue_valid = 0.
REQ-023 SHALL drive issue_ack = issue_valid and not stall.
REQ-024 SHALL, at posedge clk, increment count[issue_dest] when issue_ack and issue_wb_en.
REQ-025 SHALL, at posedge clk, decrement count[dest_wb] when write_back_en and count[dest_wb] != 0.
REQ-026 SHALL, when write_back_en and count[dest_wb] == 0, leave counts unchanged and set underflow_err = 1 at next edge.
REQ-027 SHALL leave count unchanged when increment and decrement target the same register in the same cycle.
REQ-028 SHALL never let any count exceed MAX_PENDING or wrap below 0.
REQ-029 SHALL treat an instruction whose source equals its own issue_dest as a hazard only through eff[src], not through its own issue.
REQ-030 SHALL derive pending_mask and pending_total combinationally from registered counts (one-cycle latency from issue/retire edge).
REQ-031 SHALL keep underflow_err set until reset.

Reset
REQ-032 SHALL, while rst = 1, immediately force all counts to 0 and underflow_err to 0, independent of clk.
REQ-033 SHALL, during reset, output pending_mask = 0, pending_total = 0; stall follows REQ-021 with zero counts.
REQ-034 SHALL ignore issue and write-back in any cycle where rst is high at the clock edge; reset mid-operation discards all pending entries.

Verification
REQ-035 Reset, issue dest=5 wb_en=1 -> issue_ack=1; next cycle pending_mask=0x0020, pending_total=1.
REQ-036 count[5]=1, issue src1=5 valid, no write-back -> stall=1, issue_ack=0; same with write_back_en=1 dest_wb=5 -> stall=0, issue_ack=1, count[5]=0 after edge.
REQ-037 Three accepted issues to dest=3 -> count[3]=3; fourth issue to dest=3 -> stall=1; fourth with write_back_en dest_wb=3 same cycle -> issue_ack=1, count[3] stays 3.
REQ-038 All counts 0, write_back_en=1 dest_wb=7 -> counts unchanged, underflow_err=1 next cycle and held until rst.
REQ-039 count[2]=2, count[9]=1, assert rst asynchronously mid-cycle -> pending_mask=0, pending_total=0 before next posedge clk.
REQ-040 issue src2=4 with src2_valid=0, count[4]=2 -> stall=0, issue_ack=1.
